dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL expose parameter LATENCY, default 2, meaning the number of stall cycles per access (legal range 1..15).
REQ-002 The block SHALL expose parameter AW, default 10, meaning log2 of the memory depth in 32-bit words.
REQ-003 The block SHALL expose: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL expose: rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL expose: req_en  input  1  memory-stage access request, held stable by the pipeline while stall=1.
REQ-006 The block SHALL expose: req_we  input  1  1=store, 0=load.
REQ-007 The block SHALL expose: req_size  input  2  00=byte, 01=half, 10=word; 11 reserved, treated as word.
REQ-008 The block SHALL expose: req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-009 The block SHALL expose: addr  input  32  byte address (memory-stage ALU result).
REQ-010 The block SHALL expose: wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 The block SHALL expose: rdata  output  32  formatted load data.
REQ-012 The block SHALL expose: stall  output  1  freezes the memory and writeback pipeline registers while high.
REQ-013 The block SHALL expose: addr_err  output  1  one-cycle pulse flagging a misaligned access.

Function
REQ-014 Storage SHALL be 2^AW words, little-endian, indexed by addr[AW+1:2]; higher address bits are ignored (wrap-around).
REQ-015 FSM states SHALL be IDLE, BUSY and DONE.
REQ-016 IDLE SHALL go to BUSY on an aligned req_en with the counter loaded with LATENCY-1, or directly to DONE when LATENCY=1.
REQ-017 BUSY SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reaches 0.
REQ-018 BUSY SHALL return to IDLE with no side effects if req_en drops (pipeline flush abort).
REQ-019 DONE SHALL always return to IDLE on the next edge.
REQ-020 stall SHALL equal req_en AND aligned AND (state != DONE), combinationally.
REQ-021 stall SHALL therefore be high for exactly LATENCY consecutive cycles per access, beginning in the request cycle, and SHALL be low in the DONE cycle.
REQ-022 Load data SHALL be captured into the rdata register on the edge entering DONE and SHALL be valid throughout the DONE cycle.
REQ-023 rdata SHALL hold its value until the next load completes.
REQ-024 A byte load SHALL select lane addr[1:0]; a half load SHALL select lane addr[1]; the result is then extended per req_signed.
REQ-025 A store SHALL commit on the edge ending the DONE cycle.
REQ-026 A byte store SHALL write only lane addr[1:0]; a half store SHALL write only lane addr[1]; a word store SHALL write all four lanes.
REQ-027 A half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be misaligned.
REQ-028 A misaligned access SHALL drive addr_err=1 combinationally in the request cycle, keep stall=0, leave the state IDLE, write nothing, and leave rdata unchanged.
REQ-029 A new req_en in the cycle immediately after DONE SHALL be accepted as a new access; back-to-back accesses therefore take LATENCY+1 cycles each.
REQ-030 A load following a store to the same word SHALL return the stored value.
REQ-031 req_en=0 in IDLE SHALL keep stall=0 and addr_err=0.

Reset
REQ-032 While rst=1, the FSM SHALL be forced to IDLE, the counter to 0, and rdata to 0.
REQ-033 While rst=1, stall and addr_err SHALL be 0 regardless of the other inputs.
REQ-034 Reset asserted during BUSY or DONE SHALL abort the access, with no store committed.
REQ-035 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-036 LATENCY=2: sw 0xDEADBEEF to 0x100, then lw 0x100 -> stall high 2 cycles per access; rdata=0xDEADBEEF in the DONE cycle of the load.
REQ-037 sb 0x80 to 0x101, then lb 0x101 -> rdata=0xFFFFFF80; lbu 0x101 -> rdata=0x00000080; lw 0x100 -> rdata=0xDEAD80EF.
REQ-038 lh 0x102 from word 0xDEAD80EF -> rdata=0xFFFFDEAD; lhu -> 0x0000DEAD; lw 0x102 -> addr_err=1 for 1 cycle, stall=0, rdata unchanged.
REQ-039 Store to 0x100 with req_en dropped during BUSY -> FSM in IDLE next cycle; later lw 0x100 returns the old value.
REQ-040 rst pulsed in the DONE cycle of sw 0x12345678 to 0x200 -> store not committed; rdata=0; stall=0; memory at 0x100 retained.
REQ-041 With AW=10, sw to 0x1004 followed by lw 0x0004 -> same data returned (address wrap).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for a pipelined core.
// Every aligned access stalls the pipeline for LATENCY cycles and then completes
// in a one-cycle DONE state. Loads are captured into rdata on the edge that enters
// DONE. Stores commit on the edge that ends DONE. A misaligned access is refused
// at once with a single-cycle addr_err pulse.
module dmem_responder #(
    parameter int LATENCY = 2,  // stall cycles per access, 1..15
    parameter int AW      = 10  // log2 of memory depth in 32-bit words
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err
);

    localparam int         DEPTH  = 1 << AW;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg, load_fmt;
    logic        aligned;
    logic        load_capture;
    logic        store_commit;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [3:0]  byte_en;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Address bits above the memory depth are ignored, so the memory wraps around.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    assign word_idx = addr[AW+1:2];

    // Alignment check. The reserved size 2'b11 is treated as a word.
    always_comb begin
        aligned = 1'b1;
        case (req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Handshake outputs. Both are combinational and are forced low during reset.
    // While the FSM is in BUSY, the held request is always aligned, so addr_err
    // can only pulse in the request cycle.
    assign stall    = ~rst & req_en & aligned & (state_reg != DONE);
    assign addr_err = ~rst & req_en & ~aligned;
    assign rdata    = rdata_reg;

    // Next-state and counter logic. The counter reaches 0 on the same edge that
    // enters DONE, so BUSY lasts LATENCY-1 cycles. Together with the request
    // cycle, stall is high for LATENCY cycles.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        load_capture = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_en && aligned) begin
                    if (LATENCY <= 1) begin
                        state_next   = DONE;
                        cnt_next     = 4'd0;
                        load_capture = ~req_we;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                if (!req_en) begin
                    // The pipeline flushed the access, so drop it with no side effects.
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg <= 4'd1) begin
                    state_next   = DONE;
                    cnt_next     = 4'd0;
                    load_capture = ~req_we;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A store commits on the edge that ends DONE. Reset in DONE cancels it.
    assign store_commit = (state_reg == DONE) & req_en & req_we & ~rst;

    // Lane steering for stores: replicate the right-aligned data and enable only the target lanes.
    always_comb begin
        wr_word = wdata;
        byte_en = 4'b1111;
        case (req_size)
            2'b00: begin
                wr_word = {4{wdata[7:0]}};
                byte_en = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wr_word = {2{wdata[15:0]}};
                byte_en = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_word = wdata;
                byte_en = 4'b1111;
            end
        endcase
    end

    // One byte-wide memory per lane, so that byte and half stores need no read-modify-write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        // Lane write port.
        always_ff @(posedge clk) begin
            if (store_commit && byte_en[gi]) begin
                lane_mem[word_idx] <= wr_word[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end

    // Select the load lane and apply sign or zero extension.
    always_comb begin
        ld_byte  = rd_word[8*addr[1:0] +: 8];
        ld_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_fmt = rd_word;
        case (req_size)
            2'b00:   load_fmt = {{24{req_signed & ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{16{req_signed & ld_half[15]}}, ld_half};
            default: load_fmt = rd_word;
        endcase
    end

    // Load result register. It holds its value until the next load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= 32'd0;
        end else if (load_capture) begin
            rdata_reg <= load_fmt;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2, AW=10).
// A byte-addressed reference memory models loads and stores. Every access checks
// the number of stall cycles, addr_err and rdata.
`timescale 1ns/100ps
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_en = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_signed = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata = 32'd0;
    logic [7:0]  mbytes [0:4095];

    dmem_responder #(.LATENCY(LAT), .AW(10)) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .addr(addr),
        .wdata(wdata), .rdata(rdata), .stall(stall), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sgn);
        int n;
        logic [31:0] v;
        n = nbytes(s);
        v = 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(mbytes[(a + i) & 32'hFFF]) << (8 * i));
        if (sgn && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        int n;
        n = nbytes(s);
        for (int i = 0; i < n; i++)
            mbytes[(a + i) & 32'hFFF] = wd[8*i +: 8];
    endfunction

    // Runs one access. On return it is 1 unit before the edge that ends the completing cycle.
    task automatic access(input logic we, input logic [1:0] s, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd);
        int stalls;
        bit done;
        logic mis;
        mis = (a % nbytes(s)) != 0;
        @(negedge clk);
        req_en = 1'b1; req_we = we; req_size = s; req_signed = sgn; addr = a; wdata = wd;
        stalls = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #4;
            if (stall === 1'b1) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        if (!mis && !we) exp_rdata = model_load(a, s, sgn);
        if (!mis && we) model_store(a, s, wd);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout we=%0d size=%0d addr=%h: stall never fell", we, s, a);
        end
        checks++;
        if (stalls != (mis ? 0 : LAT)) begin
            errors++;
            $display("FAIL stall_count addr=%h: got %0d want %0d", a, stalls, mis ? 0 : LAT);
        end
        checks++;
        if (addr_err !== mis) begin
            errors++;
            $display("FAIL addr_err addr=%h: got %b want %b", a, addr_err, mis);
        end
        checks++;
        if (rdata !== exp_rdata) begin
            errors++;
            $display("FAIL rdata we=%0d size=%0d sgn=%0d addr=%h: got %h want %h", we, s, sgn, a, rdata, exp_rdata);
        end
        $display("access we=%0d size=%0d sgn=%0d addr=%h wdata=%h stalls=%0d err=%b rdata=%h",
                 we, s, sgn, a, wd, stalls, addr_err, rdata);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_en = 1'b1; req_we = 1'b0; req_size = 2'b10; addr = 32'h102;
        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (stall !== 1'b0 || addr_err !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_misaligned: stall=%b err=%b rdata=%h want 0 0 0", stall, addr_err, rdata);
        end
        addr = 32'h100;
        #0.5;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        @(negedge clk);
        rst = 1'b0;
        req_en = 1'b0;
        #4;
        checks++;
        if (stall !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: stall=%b err=%b want 0 0", stall, addr_err);
        end
        $display("reset rdata=%h stall=%b addr_err=%b", rdata, stall, addr_err);
    endtask

    task automatic test_directed();
        access(1, 2'b10, 0, 32'h100, 32'hDEADBEEF);
        access(0, 2'b10, 0, 32'h100, 32'h0);
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_100: got %h want deadbeef", rdata);
        end
        access(1, 2'b00, 0, 32'h101, 32'h00000080);
        access(0, 2'b00, 1, 32'h101, 32'h0);
        checks++;
        if (rdata !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_101: got %h want ffffff80", rdata);
        end
        access(0, 2'b00, 0, 32'h101, 32'h0);
        checks++;
        if (rdata !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_101: got %h want 00000080", rdata);
        end
        access(0, 2'b10, 0, 32'h100, 32'h0);
        checks++;
        if (rdata !== 32'hDEAD80EF) begin
            errors++;
            $display("FAIL lw_merged: got %h want dead80ef", rdata);
        end
        access(0, 2'b01, 1, 32'h102, 32'h0);
        checks++;
        if (rdata !== 32'hFFFFDEAD) begin
            errors++;
            $display("FAIL lh_102: got %h want ffffdead", rdata);
        end
        access(0, 2'b01, 0, 32'h102, 32'h0);
        checks++;
        if (rdata !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL lhu_102: got %h want 0000dead", rdata);
        end
        access(0, 2'b10, 0, 32'h102, 32'h0);  // misaligned word access
        checks++;
        if (rdata !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL misaligned_rdata: got %h want 0000dead", rdata);
        end
        access(1, 2'b01, 0, 32'h103, 32'h1111);  // misaligned half store: must write nothing
        access(0, 2'b10, 0, 32'h100, 32'h0);
        checks++;
        if (rdata !== 32'hDEAD80EF) begin
            errors++;
            $display("FAIL misaligned_store_wrote: got %h want dead80ef", rdata);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        req_en = 1'b1; req_we = 1'b1; req_size = 2'b10; addr = 32'h100; wdata = 32'hCAFEF00D;
        #4;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_req_stall: got %b want 1", stall);
        end
        @(negedge clk);
        req_en = 1'b0;
        #4;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b want 0", stall);
        end
        $display("flush store 0x100 aborted in BUSY");
        access(0, 2'b10, 0, 32'h100, 32'h0);
        checks++;
        if (rdata !== 32'hDEAD80EF) begin
            errors++;
            $display("FAIL flush_old_value: got %h want dead80ef", rdata);
        end
    endtask

    task automatic test_reset_in_done();
        bit reached;
        access(1, 2'b10, 0, 32'h200, 32'hAAAA5555);
        @(negedge clk);
        req_en = 1'b1; req_we = 1'b1; req_size = 2'b10; addr = 32'h200; wdata = 32'h12345678;
        reached = 0;
        for (int c = 0; c < 40 && !reached; c++) begin
            #4;
            if (stall === 1'b0) reached = 1;
            else @(negedge clk);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rst_done_timeout: DONE never reached");
        end
        rst = 1'b1;
        #0.5;
        checks++;
        if (stall !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: stall=%b err=%b want 0 0", stall, addr_err);
        end
        @(negedge clk);
        checks++;
        if (rdata !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_state: rdata=%h stall=%b want 00000000 0", rdata, stall);
        end
        rst = 1'b0;
        req_en = 1'b0;
        exp_rdata = 32'd0;
        $display("reset pulsed in DONE of sw 0x200");
        access(0, 2'b10, 0, 32'h200, 32'h0);
        checks++;
        if (rdata !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL rst_store_committed: got %h want aaaa5555", rdata);
        end
        access(0, 2'b10, 0, 32'h100, 32'h0);
        checks++;
        if (rdata !== 32'hDEAD80EF) begin
            errors++;
            $display("FAIL rst_mem_retained: got %h want dead80ef", rdata);
        end
    endtask

    task automatic test_wrap();
        access(1, 2'b10, 0, 32'h1004, 32'h5A5AC3C3);
        access(0, 2'b10, 0, 32'h0004, 32'h0);
        checks++;
        if (rdata !== 32'h5A5AC3C3) begin
            errors++;
            $display("FAIL wrap: got %h want 5a5ac3c3", rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int w = 0; w < 16; w++)
            access(1, 2'b10, 0, 32'h300 + 32'(4 * w), $urandom);
        for (int k = 0; k < 80; k++) begin
            a = (32'h300 + 32'($urandom_range(0, 63))) | ($urandom & 32'hFFFFF000);
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_in_done();
        test_wrap();
        test_random();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
